// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: funct3 codes, FSM states, address limit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] ADDR_LIMIT_DEFAULT = 32'h0000_1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_READ,
    S_WRITE,
    S_RESP
  } lsu_state_t;

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response bundle of the load/store unit; master = core, slave = LSU.
interface lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational datapath: load byte/half extract with extension, store lane merge, request error decode.
module lsu_align
  import lsu_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
  input  logic [31:0] ld_word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] ld_data,
  input  logic [31:0] st_old,
  input  logic [31:0] st_wdata,
  output logic [31:0] st_word,
  input  logic        chk_we,
  input  logic [31:0] chk_addr,
  input  logic [2:0]  chk_funct3,
  output logic        chk_err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [1:0]  size_m1;
  logic        illegal;
  logic        misaligned;
  logic [32:0] last_byte;

  always_comb begin
    byte_sel = ld_word[7:0];
    case (offset)
      2'd1:    byte_sel = ld_word[15:8];
      2'd2:    byte_sel = ld_word[23:16];
      2'd3:    byte_sel = ld_word[31:24];
      default: byte_sel = ld_word[7:0];
    endcase
    half_sel = offset[1] ? ld_word[31:16] : ld_word[15:0];

    case (funct3)
      F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
      F3_W:    ld_data = ld_word;
      F3_BU:   ld_data = {24'b0, byte_sel};
      F3_HU:   ld_data = {16'b0, half_sel};
      default: ld_data = 32'b0;
    endcase
  end

  // Only the addressed lanes change; the rest of the word comes from the RMW read.
  always_comb begin
    st_word = st_old;
    case (funct3)
      F3_B: begin
        case (offset)
          2'd0:    st_word[7:0]   = st_wdata[7:0];
          2'd1:    st_word[15:8]  = st_wdata[7:0];
          2'd2:    st_word[23:16] = st_wdata[7:0];
          default: st_word[31:24] = st_wdata[7:0];
        endcase
      end
      F3_H: begin
        if (offset[1]) st_word[31:16] = st_wdata[15:0];
        else           st_word[15:0]  = st_wdata[15:0];
      end
      F3_W:    st_word = st_wdata;
      default: st_word = st_old;
    endcase
  end

  always_comb begin
    size_m1    = 2'd0;
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (chk_funct3)
      F3_B:  size_m1 = 2'd0;
      F3_BU: begin size_m1 = 2'd0; illegal = chk_we; end
      F3_H:  begin size_m1 = 2'd1; misaligned = chk_addr[0]; end
      F3_HU: begin size_m1 = 2'd1; misaligned = chk_addr[0]; illegal = chk_we; end
      F3_W:  begin size_m1 = 2'd3; misaligned = |chk_addr[1:0]; end
      default: illegal = 1'b1;
    endcase
    // 33-bit sum so an access near 0xFFFF_FFFF cannot wrap below the limit.
    last_byte = {1'b0, chk_addr} + {31'b0, size_m1};
    chk_err   = illegal | misaligned | (last_byte >= {1'b0, ADDR_LIMIT});
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request in flight, sub-word stores by read-modify-write on a word memory.
// Latency from accept: error 1 cycle, load/SW 2 cycles, SB/SH 3 cycles; req_ready only when idle.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  lsu_if.slave        core,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_we
);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic [31:0] ld_data;
  logic [31:0] st_word;
  logic        chk_err;

  lsu_align #(.ADDR_LIMIT(ADDR_LIMIT)) u_align (
    .ld_word    (mem_rdata),
    .offset     (addr_q[1:0]),
    .funct3     (funct3_q),
    .ld_data    (ld_data),
    .st_old     (mem_rdata),
    .st_wdata   (wdata_q),
    .st_word    (st_word),
    .chk_we     (core.req_we),
    .chk_addr   (core.req_addr),
    .chk_funct3 (core.req_funct3),
    .chk_err    (chk_err)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    funct3_d    = funct3_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (core.req_valid) begin
          addr_d   = core.req_addr;
          funct3_d = core.req_funct3;
          we_d     = core.req_we;
          wdata_d  = core.req_wdata;
          err_d    = chk_err;
          rdata_d  = 32'b0;
          if (chk_err) begin
            state_d = S_RESP;
          end else if (!core.req_we) begin
            state_d = S_LOAD;
          end else if (core.req_funct3 == F3_W) begin
            state_d     = S_WRITE;
            mem_wdata_d = core.req_wdata;
          end else begin
            state_d = S_RMW_READ;
          end
        end
      end
      S_LOAD: begin
        rdata_d = ld_data;
        state_d = S_RESP;
      end
      S_RMW_READ: begin
        // Merge against the word as read now, so the write cycle only drives registered data.
        mem_wdata_d = st_word;
        state_d     = S_WRITE;
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= 32'b0;
      funct3_q    <= 3'b0;
      we_q        <= 1'b0;
      wdata_q     <= 32'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'b0;
      mem_wdata_q <= 32'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      funct3_q    <= funct3_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  logic mem_active;
  assign mem_active      = (state_q == S_LOAD) || (state_q == S_RMW_READ) || (state_q == S_WRITE);
  assign mem_address     = mem_active ? {addr_q[31:2], 2'b00} : 32'b0;
  assign mem_wdata       = mem_wdata_q;
  assign mem_we          = (state_q == S_WRITE) && we_q;
  assign core.req_ready  = (state_q == S_IDLE);
  assign core.resp_valid = (state_q == S_RESP);
  assign core.resp_err   = (state_q == S_RESP) && err_q;
  assign core.resp_rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a word-addressed behavioural memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic        preload;

  lsu_if core_if ();

  load_store_unit dut (
    .clk         (clk),
    .reset       (reset),
    .core        (core_if.slave),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_we      (mem_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  logic [9:0]  mem_idx;
  assign mem_idx   = mem_address[11:2];
  assign mem_rdata = mem[mem_idx];

  always @(posedge clk) begin
    if (preload) begin
      mem[512]  <= 32'h8899AABB;
      mem[513]  <= 32'h11223344;
      mem[1023] <= 32'h00000000;
    end else if (mem_we) begin
      mem[mem_idx] <= mem_wdata;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic do_preload();
    @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
  endtask

  // Issues one request from idle and reports response latency (cycles after the accept edge),
  // err/rdata, how many cycles mem_we was high and in which cycle it last was.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output logic err,
                        output logic [31:0] rdata, output int we_cnt, output int we_at);
    @(negedge clk);
    core_if.req_valid  = 1'b1;
    core_if.req_we     = we;
    core_if.req_funct3 = f3;
    core_if.req_addr   = addr;
    core_if.req_wdata  = wdata;
    @(posedge clk);
    #1;
    core_if.req_valid = 1'b0;
    lat = 0; err = 1'b0; rdata = 32'b0; we_cnt = 0; we_at = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_we) begin we_cnt++; we_at = k; end
      if (core_if.resp_valid) begin
        lat = k; err = core_if.resp_err; rdata = core_if.resp_rdata;
        break;
      end
    end
  endtask

  int          lat, we_cnt, we_at;
  logic        err;
  logic [31:0] rdata;
  logic        seen_we, seen_resp;

  initial begin
    reset = 1'b1;
    preload = 1'b0;
    core_if.req_valid  = 1'b0;
    core_if.req_we     = 1'b0;
    core_if.req_funct3 = 3'b0;
    core_if.req_addr   = 32'b0;
    core_if.req_wdata  = 32'b0;
    do_preload();
    @(negedge clk);
    chk("rst_ready", {31'b0, core_if.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, core_if.resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, core_if.resp_err}, 32'd0);
    chk("rst_resp_rdata", core_if.resp_rdata, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    // Sub-word loads with sign/zero extension.
    do_req(1'b0, F3_B, 32'h803, 32'h0, lat, err, rdata, we_cnt, we_at);
    chk("lb_lat", 32'(lat), 32'd2);
    chk("lb_err", {31'b0, err}, 32'd0);
    chk("lb_rdata", rdata, 32'hFFFFFF88);
    do_req(1'b0, F3_BU, 32'h803, 32'h0, lat, err, rdata, we_cnt, we_at);
    chk("lbu_rdata", rdata, 32'h00000088);
    do_req(1'b0, F3_HU, 32'h802, 32'h0, lat, err, rdata, we_cnt, we_at);
    chk("lhu_rdata", rdata, 32'h00008899);
    do_req(1'b0, F3_H, 32'h802, 32'h0, lat, err, rdata, we_cnt, we_at);
    chk("lh_rdata", rdata, 32'hFFFF8899);
    do_req(1'b0, F3_B, 32'h800, 32'h0, lat, err, rdata, we_cnt, we_at);
    chk("lb0_rdata", rdata, 32'hFFFFFFBB);
    chk("lb_no_we", 32'(we_cnt), 32'd0);

    // SB read-modify-write.
    do_req(1'b1, F3_B, 32'h801, 32'h12345678, lat, err, rdata, we_cnt, we_at);
    chk("sb_lat", 32'(lat), 32'd3);
    chk("sb_err", {31'b0, err}, 32'd0);
    chk("sb_rdata", rdata, 32'd0);
    chk("sb_we_cnt", 32'(we_cnt), 32'd1);
    chk("sb_we_at", 32'(we_at), 32'd2);
    chk("sb_word", mem[512], 32'h889978BB);
    do_req(1'b1, F3_H, 32'h802, 32'hCAFE1234, lat, err, rdata, we_cnt, we_at);
    chk("sh_lat", 32'(lat), 32'd3);
    chk("sh_word", mem[512], 32'h123478BB);
    do_preload();

    // Error requests: no memory access, one-cycle response.
    do_req(1'b1, F3_H, 32'h801, 32'hFFFF, lat, err, rdata, we_cnt, we_at);
    chk("sh_mis_lat", 32'(lat), 32'd1);
    chk("sh_mis_err", {31'b0, err}, 32'd1);
    chk("sh_mis_we", 32'(we_cnt), 32'd0);
    do_req(1'b0, F3_W, 32'h802, 32'h0, lat, err, rdata, we_cnt, we_at);
    chk("lw_mis_lat", 32'(lat), 32'd1);
    chk("lw_mis_err", {31'b0, err}, 32'd1);
    chk("lw_mis_rdata", rdata, 32'd0);
    chk("err_word", mem[512], 32'h8899AABB);
    do_req(1'b0, F3_W, 32'hFFD, 32'h0, lat, err, rdata, we_cnt, we_at);
    chk("lw_ffd_err", {31'b0, err}, 32'd1);
    do_req(1'b1, F3_H, 32'h1000, 32'h0, lat, err, rdata, we_cnt, we_at);
    chk("sh_1000_err", {31'b0, err}, 32'd1);
    do_req(1'b0, 3'b011, 32'h800, 32'h0, lat, err, rdata, we_cnt, we_at);
    chk("ld_f3_011_err", {31'b0, err}, 32'd1);
    do_req(1'b1, F3_BU, 32'h800, 32'h0, lat, err, rdata, we_cnt, we_at);
    chk("st_f3_100_err", {31'b0, err}, 32'd1);
    chk("st_f3_100_we", 32'(we_cnt), 32'd0);

    // Range boundaries.
    do_req(1'b1, F3_W, 32'h1000, 32'h0, lat, err, rdata, we_cnt, we_at);
    chk("sw_1000_err", {31'b0, err}, 32'd1);
    chk("sw_1000_lat", 32'(lat), 32'd1);
    do_req(1'b1, F3_B, 32'hFFF, 32'h000000A5, lat, err, rdata, we_cnt, we_at);
    chk("sb_fff_err", {31'b0, err}, 32'd0);
    chk("sb_fff_word", mem[1023], 32'hA5000000);
    do_req(1'b0, F3_W, 32'hFFC, 32'h0, lat, err, rdata, we_cnt, we_at);
    chk("lw_ffc_err", {31'b0, err}, 32'd0);
    chk("lw_ffc_rdata", rdata, 32'hA5000000);
    do_req(1'b0, F3_HU, 32'hFFE, 32'h0, lat, err, rdata, we_cnt, we_at);
    chk("lhu_ffe_rdata", rdata, 32'h0000A500);
    do_req(1'b1, F3_W, 32'h808, 32'hCAFEF00D, lat, err, rdata, we_cnt, we_at);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_we_at", 32'(we_at), 32'd1);
    chk("sw_word", mem[514], 32'hCAFEF00D);

    // Reset during the RMW read of SB 0x800.
    do_preload();
    @(negedge clk);
    core_if.req_valid  = 1'b1;
    core_if.req_we     = 1'b1;
    core_if.req_funct3 = F3_B;
    core_if.req_addr   = 32'h800;
    core_if.req_wdata  = 32'h55;
    @(posedge clk);
    #1;
    core_if.req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_rd_addr", mem_address, 32'h800);
    reset = 1'b1;
    #1;
    chk("rst_mid_we", {31'b0, mem_we}, 32'd0);
    seen_we = 1'b0; seen_resp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      seen_we   = seen_we | mem_we;
      seen_resp = seen_resp | core_if.resp_valid;
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen_we   = seen_we | mem_we;
      seen_resp = seen_resp | core_if.resp_valid;
    end
    chk("rst_mid_no_we", {31'b0, seen_we}, 32'd0);
    chk("rst_mid_no_resp", {31'b0, seen_resp}, 32'd0);
    chk("rst_mid_ready", {31'b0, core_if.req_ready}, 32'd1);
    chk("rst_mid_word", mem[512], 32'h8899AABB);

    // Back-to-back LWs with req_valid held; inputs changed while busy must not leak in.
    @(negedge clk);
    core_if.req_valid  = 1'b1;
    core_if.req_we     = 1'b0;
    core_if.req_funct3 = F3_W;
    core_if.req_addr   = 32'h800;
    @(posedge clk);
    #1;
    core_if.req_addr = 32'h804;
    @(negedge clk);
    chk("b2b_busy_ready", {31'b0, core_if.req_ready}, 32'd0);
    @(negedge clk);
    chk("b2b_resp1_valid", {31'b0, core_if.resp_valid}, 32'd1);
    chk("b2b_resp1_rdata", core_if.resp_rdata, 32'h8899AABB);
    chk("b2b_resp_ready", {31'b0, core_if.req_ready}, 32'd0);
    @(negedge clk);
    chk("b2b_idle_ready", {31'b0, core_if.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    core_if.req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_accept2", {31'b0, core_if.req_ready}, 32'd0);
    @(negedge clk);
    chk("b2b_resp2_valid", {31'b0, core_if.resp_valid}, 32'd1);
    chk("b2b_resp2_rdata", core_if.resp_rdata, 32'h11223344);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
